// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared mode encodings and FSM state type for the iterative
//               shift unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    // Operation select encodings for mode_i
    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module      : shift_step
// Description : Single combinational shift stage. Shifts a WORD-bit value by
//               an amount of 0..STEP in the selected mode.
//               Build option SHIFT_UNIT_ROTATE_EN: when defined, mode 11
//               rotates left; otherwise mode 11 behaves as a logical left
//               shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
    import shift_pkg::*;
#(
    parameter  int WORD  = 32,
    parameter  int STEP  = 4,
    localparam int AMT_W = $clog2(STEP) + 1
) (
    input  logic [WORD-1:0]  i_value,
    input  logic [1:0]       i_mode,
    input  logic [AMT_W-1:0] i_amt,
    output logic [WORD-1:0]  o_result
);

    // Select the shifted value for the requested mode
    always_comb begin
        o_result = i_value;
        case (i_mode)
            MODE_SLL: o_result = i_value << i_amt;
            MODE_SRL: o_result = i_value >> i_amt;
            MODE_SRA: o_result = $signed(i_value) >>> i_amt;
`ifdef SHIFT_UNIT_ROTATE_EN
            // A right shift by WORD yields zero, so amt=0 leaves the value intact
            MODE_ROL: o_result = (i_value << i_amt) | (i_value >> (WORD - int'(i_amt)));
`else
            MODE_ROL: o_result = i_value << i_amt;
`endif
            default:  o_result = i_value;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/shift_unit_iter.sv
// ============================================================================
// Module      : shift_unit_iter
// Description : Multi-cycle shift unit. Shifts a WORD-bit operand by 0..WORD-1
//               bits, STEP bits per clock, under a valid/ready/done handshake.
//               Build option SHIFT_UNIT_ROTATE_EN enables rotate-left for
//               mode 11 (otherwise mode 11 is a logical left shift).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit_iter
    import shift_pkg::*;
#(
    parameter  int WORD = 32,
    parameter  int STEP = 4,
    localparam int SHW  = $clog2(WORD)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [1:0]      mode_i,
    input  logic [SHW-1:0]  shamt_i,
    input  logic [WORD-1:0] data_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [WORD-1:0] result_o
);

    localparam int AMT_W = $clog2(STEP) + 1;
    // STEP may equal WORD, so compare against the remaining count one bit wider
    localparam logic [SHW:0] c_STEP_W = (SHW + 1)'(STEP);

    state_t           r_state;
    logic [WORD-1:0]  r_work;
    logic [1:0]       r_mode;
    logic [SHW-1:0]   r_rem;

    logic [AMT_W-1:0] w_amt;
    logic [SHW-1:0]   w_rem_next;
    logic [WORD-1:0]  w_step;

    // Amount for this step: min(STEP, remaining)
    always_comb begin
        w_amt = AMT_W'(r_rem);
        if ({1'b0, r_rem} >= c_STEP_W) begin
            w_amt = AMT_W'(STEP);
        end
        w_rem_next = r_rem - SHW'(w_amt);
    end

    shift_step #(
        .WORD (WORD),
        .STEP (STEP)
    ) u_shift_step (
        .i_value  (r_work),
        .i_mode   (r_mode),
        .i_amt    (w_amt),
        .o_result (w_step)
    );

    assign result_o = r_work;

    // Control FSM with registered handshake outputs. After DONE the unit spends
    // one IDLE cycle with done_o high and ready_o low, then raises ready_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_mode  <= MODE_SLL;
            r_rem   <= '0;
            ready_o <= 1'b1;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!ready_o) begin
                        ready_o <= 1'b1;
                    end else if (valid_i && !kill_i) begin
                        r_work  <= data_i;
                        r_mode  <= mode_i;
                        r_rem   <= shamt_i;
                        ready_o <= 1'b0;
                        r_state <= (shamt_i == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (kill_i) begin
                        r_state <= ST_IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        r_work <= w_step;
                        r_rem  <= w_rem_next;
                        if (w_rem_next == '0) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (kill_i) begin
                        ready_o <= 1'b1;
                    end else begin
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
